pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 opcode  input  6  instruction opcode, valid from ID onward.
REQ-005 funct  input  6  R-type function field, valid from ID onward.
REQ-006 zero  input  1  ALU zero flag, valid in EXE.
REQ-007 mem_ready  input  1  memory done; used only with MEM_WAIT_EN.
REQ-008 pc_write  output  1  PC load enable.
REQ-009 pc_sel  output  2  next-PC select: 0 NextIns, 1 RelJmp, 2 AbsJmp, 3 RsJmp.
REQ-010 ir_write  output  1  instruction register load.
REQ-011 reg_write  output  1  register file write.
REQ-012 mem_read, mem_write  output  1 each  data memory strobes.
REQ-013 state  output  3  current state code.
REQ-014 halted  output  1  high while in HALT.

Function
REQ-015 SHALL be a Moore FSM: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to IF next cycle with all strobes 0.
REQ-016 IF: ir_write=1; next ID.
REQ-017 ID decode: j (0x02) -> pc_write=1, pc_sel=2, next IF; jal (0x03) -> same plus reg_write=1; R-type funct 0x08 (jr) -> pc_write=1, pc_sel=3, next IF; halt (0x3F) -> HALT; all other defined ops -> EXE.
REQ-018 Undefined opcodes SHALL complete in ID as NOP: pc_write=1, pc_sel=0, next IF.
REQ-019 EXE: beq (0x04)/bne (0x05) -> pc_write=1, pc_sel=1 if taken (beq: zero=1; bne: zero=0), else pc_sel=0; next IF; lw (0x23)/sw (0x2B) -> MEM; R-type/addi (0x08)/ori (0x0D) -> WB.
REQ-020 MEM: lw -> mem_read=1, next WB; sw -> mem_write=1, pc_write=1, pc_sel=0, next IF.
REQ-021 WB: reg_write=1, pc_write=1, pc_sel=0; next IF.
REQ-022 Latency in cycles: j/jal/jr/NOP 2, branch 3, R/addi/ori/sw 4, lw 5.
REQ-023 pc_write SHALL be asserted exactly once per instruction, in its final state; never in IF or HALT.
REQ-024 pc_sel SHALL be 0 in every state where pc_write=0.
REQ-025 HALT SHALL be absorbing: halted=1, all strobes 0, exit only via RST.

Reset
REQ-026 RST high at a clock edge SHALL force state IF on that edge, overriding all transitions, including mid-instruction and in HALT.
REQ-027 Outputs during/after reset SHALL equal IF decoding: ir_write=1, all other outputs 0, state=0.

Configuration
REQ-028 Macro MEM_WAIT_EN defined: MEM SHALL hold (strobe held, pc_write=0) until mem_ready=1, then perform REQ-020 actions in that cycle and transition.
REQ-029 Macro MEM_WAIT_EN undefined: mem_ready SHALL be ignored; MEM lasts exactly one cycle.

Structure
REQ-030 State codes, pc_sel codes (NextIns, RelJmp, AbsJmp, RsJmp) and opcode/funct constants SHALL live in the shared header used by the PC next-address logic.
REQ-031 One sub-module, pc_seq_decode (combinational opcode/funct to instruction class), SHALL be used; FSM register stays in pc_sequencer.

Verification
REQ-032 RST=1 for 2 cycles then 0 -> state=0, ir_write=1, pc_write=0; state=1 next cycle.
REQ-033 opcode=0x23 (lw) -> states 0,1,2,3,4; mem_read=1 in state 3 only; reg_write=1 and pc_write=1, pc_sel=0 in state 4.
REQ-034 opcode=0x04, zero=1 -> pc_write=1, pc_sel=1 in EXE; repeat with zero=0 -> pc_sel=0; bne 0x05 with zero=0 -> pc_sel=1.
REQ-035 opcode=0x03 -> pc_write=1, pc_sel=2, reg_write=1 in ID; opcode=0, funct=0x08 -> pc_sel=3 in ID.
REQ-036 MEM_WAIT_EN, sw, mem_ready=0 for 3 cycles then 1 -> mem_write=1 for 4 cycles, single pc_write on the 4th.
REQ-037 opcode=0x3F -> HALT, halted=1 for 10 cycles with no pc_write; RST=1 asserted in EXE of an addi -> next state IF, no reg_write.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer_pkg
// Brief    : Shared state, next-PC select, opcode/funct and instruction-class
//            definitions for the PC sequencer and the PC next-address logic.
// Revision : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_NEXT_INS = 2'd0,
        SEL_REL_JMP  = 2'd1,
        SEL_ABS_JMP  = 2'd2,
        SEL_RS_JMP   = 2'd3
    } pc_sel_t;

    typedef enum logic [3:0] {
        CLS_NOP  = 4'd0,
        CLS_J    = 4'd1,
        CLS_JAL  = 4'd2,
        CLS_JR   = 4'd3,
        CLS_HALT = 4'd4,
        CLS_BEQ  = 4'd5,
        CLS_BNE  = 4'd6,
        CLS_LW   = 4'd7,
        CLS_SW   = 4'd8,
        CLS_ALU  = 4'd9
    } instr_cls_t;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_bne   = 6'h05;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_ori   = 6'h0D;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_halt  = 6'h3F;
    localparam logic [5:0] c_fn_jr    = 6'h08;

endpackage
`default_nettype wire

// File: rtl/pc_seq_decode.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_decode
// Brief    : Combinational opcode/funct to instruction-class decoder.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq_decode
    import pc_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] cls
);

    instr_cls_t w_cls;

    always_comb begin
        w_cls = CLS_NOP;
        case (opcode)
            c_op_rtype: w_cls = (funct == c_fn_jr) ? CLS_JR : CLS_ALU;
            c_op_j:     w_cls = CLS_J;
            c_op_jal:   w_cls = CLS_JAL;
            c_op_beq:   w_cls = CLS_BEQ;
            c_op_bne:   w_cls = CLS_BNE;
            c_op_addi:  w_cls = CLS_ALU;
            c_op_ori:   w_cls = CLS_ALU;
            c_op_lw:    w_cls = CLS_LW;
            c_op_sw:    w_cls = CLS_SW;
            c_op_halt:  w_cls = CLS_HALT;
            default:    w_cls = CLS_NOP;
        endcase
    end

    assign cls = w_cls;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Multi-cycle PC/control sequencer FSM (IF/ID/EXE/MEM/WB/HALT).
//            Optional macro MEM_WAIT_EN stretches MEM until mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_sel,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] state,
    output logic       halted
);

    state_t     r_state;
    instr_cls_t r_cls;
    instr_cls_t w_cls;
    logic [3:0] w_cls_raw;
    logic       w_mem_done;

    logic       w_pc_write;
    pc_sel_t    w_pc_sel;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_halted;
    logic [2:0] w_state;

    pc_seq_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (w_cls_raw)
    );

    assign w_cls = instr_cls_t'(w_cls_raw);

`ifdef MEM_WAIT_EN
    assign w_mem_done = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_done         = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IF;
            r_cls   <= CLS_NOP;
        end else begin
            case (r_state)
                ST_IF: r_state <= ST_ID;
                ST_ID: begin
                    // Fields are only guaranteed from ID on, so capture the class here
                    r_cls <= w_cls;
                    case (w_cls)
                        CLS_J, CLS_JAL, CLS_JR, CLS_NOP: r_state <= ST_IF;
                        CLS_HALT:                         r_state <= ST_HALT;
                        default:                          r_state <= ST_EXE;
                    endcase
                end
                ST_EXE: begin
                    case (r_cls)
                        CLS_LW, CLS_SW: r_state <= ST_MEM;
                        CLS_ALU:        r_state <= ST_WB;
                        default:        r_state <= ST_IF;
                    endcase
                end
                ST_MEM: begin
                    if (w_mem_done) begin
                        r_state <= (r_cls == CLS_LW) ? ST_WB : ST_IF;
                    end
                end
                ST_WB:   r_state <= ST_IF;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_IF;
            endcase
        end
    end

    // Outputs follow the registered state but ID/EXE need fields valid only then
    always_comb begin
        w_pc_write  = 1'b0;
        w_pc_sel    = SEL_NEXT_INS;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_halted    = 1'b0;
        w_state     = r_state;
        if (RST) begin
            w_ir_write = 1'b1;
            w_state    = ST_IF;
        end else begin
            case (r_state)
                ST_IF: w_ir_write = 1'b1;
                ST_ID: begin
                    case (w_cls)
                        CLS_J: begin
                            w_pc_write = 1'b1;
                            w_pc_sel   = SEL_ABS_JMP;
                        end
                        CLS_JAL: begin
                            w_pc_write  = 1'b1;
                            w_pc_sel    = SEL_ABS_JMP;
                            w_reg_write = 1'b1;
                        end
                        CLS_JR: begin
                            w_pc_write = 1'b1;
                            w_pc_sel   = SEL_RS_JMP;
                        end
                        CLS_NOP: w_pc_write = 1'b1;
                        default: ;
                    endcase
                end
                ST_EXE: begin
                    if (r_cls == CLS_BEQ) begin
                        w_pc_write = 1'b1;
                        w_pc_sel   = zero ? SEL_REL_JMP : SEL_NEXT_INS;
                    end else if (r_cls == CLS_BNE) begin
                        w_pc_write = 1'b1;
                        w_pc_sel   = zero ? SEL_NEXT_INS : SEL_REL_JMP;
                    end
                end
                ST_MEM: begin
                    if (r_cls == CLS_LW) begin
                        w_mem_read = 1'b1;
                    end else if (r_cls == CLS_SW) begin
                        w_mem_write = 1'b1;
                        w_pc_write  = w_mem_done;
                    end
                end
                ST_WB: begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                end
                ST_HALT: w_halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_write  = w_pc_write;
    assign pc_sel    = w_pc_sel;
    assign ir_write  = w_ir_write;
    assign reg_write = w_reg_write;
    assign mem_read  = w_mem_read;
    assign mem_write = w_mem_write;
    assign state     = w_state;
    assign halted    = w_halted;

endmodule
`default_nettype wire
